debug_frame_tx: RTL and testbench
=================================

DEBUG_FRAME_TX -- requirements
Module: debug_frame_tx

Interface
REQ-001 The block SHALL take parameter DATA_W, default 64, as the snapshot width in bits (8..524280).
REQ-002 The block SHALL take parameter HDR_BYTE, default 8'hA5, as the frame start byte.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port sendSignal, input, 1 bit: request to capture and transmit one frame.
REQ-007 The block SHALL have port sendData, input, DATA_W bits: debug snapshot bus.
REQ-008 The block SHALL have port tx_busy, input, 1 bit: UART transmitter occupied.
REQ-009 The block SHALL have port wr_uart, output, 1 bit: one-cycle byte-write strobe to the UART.
REQ-010 The block SHALL have port w_data, output, 8 bits: byte to transmit, valid while wr_uart=1.
REQ-011 The block SHALL have port dataSent, output, 1 bit: one-cycle pulse after the last frame byte completes.
REQ-012 The block SHALL have port busy, output, 1 bit: frame in progress.
REQ-013 The block SHALL have port state_reg_tx, output, 3 bits: current state encoding, for debug.

Function
REQ-014 NBYTES SHALL equal ceil(DATA_W/8); the snapshot SHALL be zero-padded at the MSB end to NBYTES*8 bits.
REQ-015 The frame SHALL be sent in this order:
- HDR_BYTE;
- NBYTES as 16 bits, high byte first;
- the snapshot bytes, most significant first;
- the checksum byte, when configured (REQ-027).
REQ-016 The states SHALL be IDLE=0, HDR=1, LEN=2, DATA=3, CSUM=4, WAIT=5, DONE=6.
REQ-017 In IDLE, sendSignal=1 SHALL capture sendData into an internal register and move to HDR on the next edge.
REQ-018 Changes to sendData after capture SHALL NOT affect the frame in progress.
REQ-019 In a send state (HDR, LEN, DATA, CSUM) with tx_busy=0, the block SHALL assert wr_uart for exactly one cycle with w_data set, then enter WAIT.
REQ-020 WAIT SHALL ignore tx_busy for one guard cycle, then hold until tx_busy=0.
- On leaving WAIT it SHALL go to the next send state, or to DONE after the final byte.
- UART contract: tx_busy rises no later than the cycle after wr_uart.
REQ-021 DONE SHALL assert dataSent for exactly one cycle and return to IDLE.
REQ-022 The first header strobe SHALL occur one cycle after sendSignal is accepted, provided tx_busy=0.
REQ-023 sendSignal SHALL be ignored while busy=1; it SHALL be level-sampled, so holding it high in IDLE immediately after DONE starts a new frame.
REQ-024 The byte counter SHALL count down NBYTES-1..0 with no wrap; DATA_W=8 SHALL produce exactly one data byte.
REQ-025 wr_uart and dataSent SHALL never be asserted in the same cycle.

Reset
REQ-026 Reset, including reset asserted mid-frame, SHALL immediately give:
- state IDLE;
- wr_uart=0, dataSent=0, busy=0;
- w_data=8'h00, state_reg_tx=3'd0;
- capture register, counter and checksum cleared;
- no partial-frame resumption after release.

Configuration
REQ-027 With DEBUG_FRAME_TX_CHECKSUM_EN defined:
- a CSUM byte SHALL follow the data bytes;
- its value SHALL be the XOR of both length bytes and all data bytes, excluding the header.
REQ-028 With DEBUG_FRAME_TX_CHECKSUM_EN undefined, the CSUM state SHALL be unreachable and DONE SHALL follow the last data byte.

Structure
REQ-029 The shared package debug_pkg SHALL hold:
- the state enumeration;
- the default HDR_BYTE;
- the byte-width constant;
- the NBYTES helper function.
REQ-030 The UART strobe/guard/wait logic SHALL live in sub-module uart_byte_handshake; the FSM, capture register, counter and checksum SHALL stay in debug_frame_tx.

Verification
REQ-031 DATA_W=16, sendData=16'h1234, checksum enabled, tx_busy model 3 cycles -> bytes A5,00,02,12,34,24, then one dataSent pulse.
REQ-032 DATA_W=12, sendData=12'hABC, checksum disabled -> bytes A5,00,02,0A,BC; no CSUM state is visited.
REQ-033 tx_busy held high for 20 cycles at frame start -> no wr_uart until tx_busy falls; header strobe on the first low cycle.
REQ-034 sendSignal pulsed again during DATA and sendData changed mid-frame -> a single frame carrying the captured value; no second frame.
REQ-035 reset asserted during the second data byte -> outputs at reset values within the same cycle; after release plus sendSignal, a fresh complete frame starting with A5.
REQ-036 DATA_W=8, sendData=8'hFF, checksum enabled -> bytes A5,00,01,FF,FE.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types and constants for the debug frame transmitter.
// Holds the FSM state encoding, the default header and the byte-count helper.
package debug_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LEN  = 3'd2,
    S_DATA = 3'd3,
    S_CSUM = 3'd4,
    S_WAIT = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;
  localparam int         BYTE_W      = 8;

  function automatic int nbytes(input int w);
    return (w + BYTE_W - 1) / BYTE_W;
  endfunction

endpackage

// File: rtl/debug_frame_tx_if.sv
// Byte-level UART link: write strobe and data out, busy back.
// The master side drives the strobe, the UART side reports busy.
interface debug_frame_tx_if;

  logic       tx_busy;
  logic       wr_uart;
  logic [7:0] w_data;

  modport master (
    input  tx_busy,
    output wr_uart,
    output w_data
  );

  modport slave (
    output tx_busy,
    input  wr_uart,
    input  w_data
  );

endinterface

// File: rtl/uart_byte_handshake.sv
// One-byte UART handshake: strobe, one guard cycle, then wait for idle.
// ack marks the cycle in which the byte is fully handed over.
module uart_byte_handshake (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [7:0]       byte_in,
  output logic             fire,
  output logic             ack,
  debug_frame_tx_if.master uart
);

  logic waiting;

  assign fire = req & ~uart.tx_busy;
  // the strobe cycle itself is the guard: busy may not have risen yet
  assign ack  = waiting & ~uart.wr_uart & ~uart.tx_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart.wr_uart <= 1'b0;
      uart.w_data  <= 8'h00;
      waiting      <= 1'b0;
    end else begin
      uart.wr_uart <= fire;
      if (fire) begin
        uart.w_data <= byte_in;
        waiting     <= 1'b1;
      end else if (ack) begin
        waiting     <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/debug_frame_tx.sv
// Frames a captured snapshot as HDR, 16-bit length, data MSB first.
// Define DEBUG_FRAME_TX_CHECKSUM_EN to append an XOR checksum byte.
module debug_frame_tx
  import debug_pkg::*;
#(
  parameter int         DATA_W   = 64,
  parameter logic [7:0] HDR_BYTE = HDR_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sendSignal,
  input  logic [DATA_W-1:0] sendData,
  input  logic              tx_busy,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  output logic              dataSent,
  output logic              busy,
  output logic [2:0]        state_reg_tx
);

  localparam int NB = nbytes(DATA_W);
  localparam int PW = NB * BYTE_W;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [15:0]   LEN     = 16'(NB);
  localparam logic [CW-1:0] CNT_TOP = CW'(NB - 1);

`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
  localparam state_t LAST_NEXT = S_CSUM;
`else
  localparam state_t LAST_NEXT = S_DONE;
`endif

  state_t        state;
  state_t        ret;
  logic [PW-1:0] snap;
  logic [CW-1:0] cnt;
  logic          len_lo;
  logic [7:0]    tx_byte;
  logic          req;
  logic          fire;
  logic          ack;

  debug_frame_tx_if u_uart ();

  assign u_uart.tx_busy = tx_busy;
  assign wr_uart        = u_uart.wr_uart;
  assign w_data         = u_uart.w_data;
  assign state_reg_tx   = state;

  assign req = (state == S_HDR) | (state == S_LEN)
             | (state == S_DATA) | (state == S_CSUM);

`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      csum <= 8'h00;
    end else if (state == S_IDLE) begin
      csum <= 8'h00;
    end else if (fire && (state == S_LEN || state == S_DATA)) begin
      csum <= csum ^ tx_byte;
    end
  end
`endif

  always_comb begin
    tx_byte = 8'h00;
    unique case (1'b1)
      state == S_HDR:  tx_byte = HDR_BYTE;
      state == S_LEN:  tx_byte = len_lo ? LEN[7:0] : LEN[15:8];
      state == S_DATA: tx_byte = snap[{cnt, 3'b000} +: 8];
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
      state == S_CSUM: tx_byte = csum;
`endif
      default:         tx_byte = 8'h00;
    endcase
  end

  uart_byte_handshake u_hs (
    .clk     (clock),
    .rst_n   (reset),
    .req     (req),
    .byte_in (tx_byte),
    .fire    (fire),
    .ack     (ack),
    .uart    (u_uart)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      ret      <= S_IDLE;
      snap     <= '0;
      cnt      <= '0;
      len_lo   <= 1'b0;
      dataSent <= 1'b0;
      busy     <= 1'b0;
    end else begin
      dataSent <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (sendSignal) begin
            snap   <= PW'(sendData);
            cnt    <= CNT_TOP;
            len_lo <= 1'b0;
            busy   <= 1'b1;
            state  <= S_HDR;
          end
        end
        S_HDR: begin
          if (fire) begin
            ret   <= S_LEN;
            state <= S_WAIT;
          end
        end
        S_LEN: begin
          if (fire) begin
            ret    <= len_lo ? S_DATA : S_LEN;
            len_lo <= 1'b1;
            state  <= S_WAIT;
          end
        end
        S_DATA: begin
          if (fire) begin
            state <= S_WAIT;
            if (cnt == '0) begin
              ret <= LAST_NEXT;
            end else begin
              ret <= S_DATA;
              cnt <= cnt - 1'b1;
            end
          end
        end
        S_CSUM: begin
          if (fire) begin
            ret   <= S_DONE;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ack) begin
            state    <= ret;
            dataSent <= (ret == S_DONE);
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_frame_tx.sv
// Directed bench for debug_frame_tx at DATA_W 16, 12 and 8.
// Expected byte streams follow DEBUG_FRAME_TX_CHECKSUM_EN.
module tb_debug_frame_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_frame_tx_if u16 ();
  debug_frame_tx_if u12 ();
  debug_frame_tx_if u8i ();

  logic        s16, s12, s8;
  logic [15:0] d16;
  logic [11:0] d12;
  logic [7:0]  d8;
  logic        ds16, ds12, ds8;
  logic        b16, b12, b8;
  logic [2:0]  st16, st12, st8;
  logic        hold16;
  int          bc16, bc12, bc8;

  logic [7:0] q16[$];
  logic [7:0] q12[$];
  logic [7:0] q8[$];
  int n16 = 0, n12 = 0, n8 = 0, ovl = 0;
  bit cs12 = 1'b0;

  int n_pass = 0, n_chk = 0;

  debug_frame_tx #(.DATA_W(16)) dut16 (
    .clock(clk), .reset(rst_n), .sendSignal(s16), .sendData(d16),
    .tx_busy(u16.tx_busy), .wr_uart(u16.wr_uart), .w_data(u16.w_data),
    .dataSent(ds16), .busy(b16), .state_reg_tx(st16)
  );

  debug_frame_tx #(.DATA_W(12)) dut12 (
    .clock(clk), .reset(rst_n), .sendSignal(s12), .sendData(d12),
    .tx_busy(u12.tx_busy), .wr_uart(u12.wr_uart), .w_data(u12.w_data),
    .dataSent(ds12), .busy(b12), .state_reg_tx(st12)
  );

  debug_frame_tx #(.DATA_W(8)) dut8 (
    .clock(clk), .reset(rst_n), .sendSignal(s8), .sendData(d8),
    .tx_busy(u8i.tx_busy), .wr_uart(u8i.wr_uart), .w_data(u8i.w_data),
    .dataSent(ds8), .busy(b8), .state_reg_tx(st8)
  );

  // UART models: busy for 3 cycles starting the cycle after the strobe
  assign u16.tx_busy = hold16 | (bc16 != 0);
  assign u12.tx_busy = (bc12 != 0);
  assign u8i.tx_busy = (bc8 != 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bc16 <= 0; bc12 <= 0; bc8 <= 0;
    end else begin
      bc16 <= u16.wr_uart ? 3 : (bc16 != 0 ? bc16 - 1 : 0);
      bc12 <= u12.wr_uart ? 3 : (bc12 != 0 ? bc12 - 1 : 0);
      bc8  <= u8i.wr_uart ? 3 : (bc8 != 0 ? bc8 - 1 : 0);
    end
  end

  always @(negedge clk) begin
    if (u16.wr_uart) q16.push_back(u16.w_data);
    if (u12.wr_uart) q12.push_back(u12.w_data);
    if (u8i.wr_uart) q8.push_back(u8i.w_data);
    if (ds16) n16++;
    if (ds12) n12++;
    if (ds8)  n8++;
    if ((u16.wr_uart && ds16) || (u12.wr_uart && ds12) || (u8i.wr_uart && ds8))
      ovl++;
    if (st12 == 3'd4) cs12 = 1'b1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] got[$],
                             input logic [7:0] exp[$]);
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_b%0d", tag, i), got[i], exp[i]);
  endtask

  task automatic wait_frame(input int which, input int base, input string tag);
    int k = 0;
    int cur = base;
    while (cur == base && k < 400) begin
      step(1);
      k++;
      cur = (which == 0) ? n16 : (which == 1) ? n12 : n8;
    end
    check({tag, "_done"}, 32'(cur != base), 1);
  endtask

  logic [7:0] e[$];
  int k;

  initial begin
    s16 = 0; s12 = 0; s8 = 0; hold16 = 0;
    d16 = '0; d12 = '0; d8 = '0;
    step(2);
    check("rst_wr", u16.wr_uart, 0);
    check("rst_ds", ds16, 0);
    check("rst_busy", b16, 0);
    check("rst_wdata", u16.w_data, 8'h00);
    check("rst_state", st16, 3'd0);
    rst_n = 1;
    step(2);

    // basic 16-bit frame and first-strobe latency
    d16 = 16'h1234; s16 = 1;
    step(1);
    check("t1_hdr_state", st16, 3'd1);
    check("t1_busy", b16, 1);
    check("t1_no_wr_yet", u16.wr_uart, 0);
    s16 = 0;
    step(1);
    check("t1_hdr_wr", u16.wr_uart, 1);
    check("t1_hdr_byte", u16.w_data, 8'hA5);
    check("t1_wait_state", st16, 3'd5);
    wait_frame(0, 0, "t1");
    e = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34};
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
    e.push_back(8'h24);
`endif
    check_frame("t1", q16, e);
    step(5);
    check("t1_one_pulse", n16, 1);
    check("t1_idle_busy", b16, 0);
    check("t1_idle_state", st16, 3'd0);

    // header held off by tx_busy
    q16.delete();
    hold16 = 1; d16 = 16'hBEEF; s16 = 1;
    step(1);
    s16 = 0;
    step(20);
    check("t2_no_wr", q16.size(), 0);
    check("t2_in_hdr", st16, 3'd1);
    hold16 = 0;
    step(1);
    check("t2_hdr_wr", u16.wr_uart, 1);
    check("t2_hdr_byte", u16.w_data, 8'hA5);
    wait_frame(0, 1, "t2");
    e = '{8'hA5, 8'h00, 8'h02, 8'hBE, 8'hEF};
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
    e.push_back(8'h53);
`endif
    check_frame("t2", q16, e);

    // retrigger and data change mid-frame
    step(2);
    q16.delete();
    d16 = 16'hCAFE; s16 = 1;
    step(1);
    s16 = 0;
    k = 0;
    while (st16 != 3'd3 && k < 100) begin step(1); k++; end
    check("t3_reach_data", st16, 3'd3);
    s16 = 1; d16 = 16'h0000;
    step(2);
    s16 = 0;
    wait_frame(0, 2, "t3");
    e = '{8'hA5, 8'h00, 8'h02, 8'hCA, 8'hFE};
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
    e.push_back(8'h36);
`endif
    check_frame("t3", q16, e);
    step(40);
    check("t3_single_frame", n16, 3);
    check("t3_no_extra_bytes", q16.size(), e.size());
    check("t3_idle", b16, 0);

    // reset during the second data byte
    q16.delete();
    d16 = 16'h5678; s16 = 1;
    step(1);
    s16 = 0;
    k = 0;
    while (q16.size() < 5 && k < 200) begin step(1); k++; end
    check("t4_second_data", q16.size(), 5);
    rst_n = 0;
    #1;
    check("t4_rst_wr", u16.wr_uart, 0);
    check("t4_rst_wdata", u16.w_data, 8'h00);
    check("t4_rst_busy", b16, 0);
    check("t4_rst_ds", ds16, 0);
    check("t4_rst_state", st16, 3'd0);
    step(2);
    rst_n = 1;
    q16.delete();
    step(30);
    check("t4_no_resume", q16.size(), 0);
    check("t4_idle_state", st16, 3'd0);
    d16 = 16'h9ABC; s16 = 1;
    step(1);
    s16 = 0;
    wait_frame(0, 3, "t4");
    e = '{8'hA5, 8'h00, 8'h02, 8'h9A, 8'hBC};
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
    e.push_back(8'h24);
`endif
    check_frame("t4", q16, e);

    // 12-bit snapshot, zero padded
    d12 = 12'hABC; s12 = 1;
    step(1);
    s12 = 0;
    wait_frame(1, 0, "t5");
    e = '{8'hA5, 8'h00, 8'h02, 8'h0A, 8'hBC};
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
    e.push_back(8'hB4);
    check("t5_csum_state", 32'(cs12), 1);
`else
    check("t5_csum_state", 32'(cs12), 0);
`endif
    check_frame("t5", q12, e);

    // 8-bit snapshot, single data byte
    d8 = 8'hFF; s8 = 1;
    step(1);
    s8 = 0;
    wait_frame(2, 0, "t6");
    e = '{8'hA5, 8'h00, 8'h01, 8'hFF};
`ifdef DEBUG_FRAME_TX_CHECKSUM_EN
    e.push_back(8'hFE);
`endif
    check_frame("t6", q8, e);
    step(5);
    check("t6_one_pulse", n8, 1);
    check("no_wr_ds_overlap", ovl, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
